shift_sequencer: RTL

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_if.sv | 23 ++
 rtl/shift_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the multi-cycle shift sequencer.
// The master drives the request, and the slave (the sequencer) returns the result and status.
interface shift_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic        amt_sel;
    logic [4:0]  shamt;
    logic [31:0] amt_reg;
    logic [31:0] data_in;
    logic [31:0] result;
    logic        busy;
    logic        done;

    modport master (
        output start, op, amt_sel, shamt, amt_reg, data_in,
        input  result, busy, done
    );

    modport slave (
        input  start, op, amt_sel, shamt, amt_reg, data_in,
        output result, busy, done
    );
endinterface

// File: rtl/shift_sequencer.sv
// Bit-serial shifter that moves a 32-bit operand one position per cycle.
// It supports SLL, SRL, SRA and ROTR, and pulses done when the full amount has been applied.
module shift_sequencer (
    input  logic                     clk,
    input  logic                     reset,
    shift_sequencer_if.slave         sif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] work_r;
    logic [31:0] work_nxt_s;
    logic [4:0]  cnt_r;
    logic [4:0]  cnt_nxt_s;
    logic [1:0]  op_r;
    logic [1:0]  op_nxt_s;
    logic        busy_r;
    logic        done_r;
    logic [4:0]  amount_s;
    logic        amt_hi_unused_s;

    // Only the low five bits of the register operand form the amount.
    assign amt_hi_unused_s = ^sif.amt_reg[31:5];
    assign amount_s        = sif.amt_sel ? sif.amt_reg[4:0] : sif.shamt;

    function automatic logic [31:0] shift_one(input logic [1:0] op, input logic [31:0] val);
        logic [31:0] res;
        case (op)
            OP_SLL:  res = {val[30:0], 1'b0};
            OP_SRL:  res = {1'b0, val[31:1]};
            OP_SRA:  res = {val[31], val[31:1]};
            OP_ROTR: res = {val[0], val[31:1]};
            default: res = val;
        endcase
        return res;
    endfunction

    // Next-state, datapath and counter update
    always_comb begin
        state_nxt_s = state_r;
        work_nxt_s  = work_r;
        cnt_nxt_s   = cnt_r;
        op_nxt_s    = op_r;
        case (state_r)
            ST_IDLE: begin
                if (sif.start) begin
                    work_nxt_s  = sif.data_in;
                    op_nxt_s    = sif.op;
                    cnt_nxt_s   = amount_s;
                    state_nxt_s = (amount_s == 5'd0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_nxt_s = shift_one(op_r, work_r);
                // A zero count here is unreachable; leave rather than wrap.
                if (cnt_r <= 5'd1) begin
                    cnt_nxt_s   = 5'd0;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s   = cnt_r - 5'd1;
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            work_r  <= 32'h0000_0000;
            cnt_r   <= 5'd0;
            op_r    <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            work_r  <= work_nxt_s;
            cnt_r   <= cnt_nxt_s;
            op_r    <= op_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign sif.result = work_r;
    assign sif.busy   = busy_r;
    assign sif.done   = done_r;

endmodule
